tmc_spi_responder: RTL and testbench

- Synthesizable SPI responder that emulates the register interface of the TMC2130-class stepper driver programmed by motor_driver.
- Sits on the far end of the 40-bit SPI link as a loopback target for simulation and FPGA self-test. Also usable as a register-shadow front end for a soft driver.
- Decodes 40-bit frames (8-bit address, bit7 = write, plus 32-bit data), holds a register file and returns pipelined read data with a status byte.
- Measures step timing (TSTEP) and the microstep count (MSCNT) from the step/dir pins.

---
 rtl/tmc_spi_responder_if.sv | 26 ++
 rtl/tmc_spi_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_tmc_spi_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tmc_spi_responder_if.sv
// SPI link between the motor_driver initiator and tmc_spi_responder.
// Signal names match the responder's original scalar ports.
//   sclk_in   : SPI clock, mode 3 (idle high), initiator -> responder
//   cs_n_in   : chip select, active low, initiator -> responder
//   mosi_in   : serial data, MSB first, initiator -> responder
//   miso_out  : serial data, MSB first, responder -> initiator
interface tmc_spi_responder_if;
  logic sclk_in;
  logic cs_n_in;
  logic mosi_in;
  logic miso_out;

  modport master (
    output sclk_in,
    output cs_n_in,
    output mosi_in,
    input  miso_out
  );

  modport slave (
    input  sclk_in,
    input  cs_n_in,
    input  mosi_in,
    output miso_out
  );
endinterface

// File: rtl/tmc_spi_responder.sv
// SPI responder emulating the TMC2130-class register interface.
// Decodes 40-bit frames ({addr[7:0], data[31:0]}, addr[7] = write), keeps a
// register shadow, and returns the register addressed by the previous frame
// together with a status byte. Also measures the step interval (TSTEP) and
// the microstep position (MSCNT) from the step/dir pins.
//
// Ports:
//   clk_in          : system clock, at least 4x the SPI clock
//   reset_n_in      : asynchronous active-low reset
//   spi             : SPI link (slave modport: sclk_in, cs_n_in, mosi_in, miso_out)
//   step_in         : step pulse input
//   dir_in          : direction, 1 counts MSCNT up, 0 down
//   gconf_out       : GCONF shadow
//   chopconf_out    : CHOPCONF shadow
//   ihold_irun_out  : IHOLD_IRUN shadow
//   frame_done_out  : one-cycle pulse per committed 40-bit frame
//   frame_error_out : one-cycle pulse when CS rises with bit count != 40
module tmc_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TSTEP_WIDTH = 20
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  tmc_spi_responder_if.slave   spi,
  input  logic                 step_in,
  input  logic                 dir_in,
  output logic [31:0]          gconf_out,
  output logic [31:0]          chopconf_out,
  output logic [31:0]          ihold_irun_out,
  output logic                 frame_done_out,
  output logic                 frame_error_out
);

  // Synchronizer bit order: {dir, step, mosi, cs_n, sclk}; idle = sclk/cs_n high.
  localparam logic [4:0] SYNC_IDLE = 5'b00011;
  localparam logic [TSTEP_WIDTH-1:0] TSTEP_MAX = '1;
  localparam logic [5:0] FRAME_BITS = 6'd40;

  localparam logic [6:0] ADDR_GCONF      = 7'h00;
  localparam logic [6:0] ADDR_GSTAT      = 7'h01;
  localparam logic [6:0] ADDR_IHOLD_IRUN = 7'h10;
  localparam logic [6:0] ADDR_TPOWERDOWN = 7'h11;
  localparam logic [6:0] ADDR_TSTEP      = 7'h12;
  localparam logic [6:0] ADDR_THIGH      = 7'h15;
  localparam logic [6:0] ADDR_MSCNT      = 7'h6A;
  localparam logic [6:0] ADDR_CHOPCONF   = 7'h6C;
  localparam logic [6:0] ADDR_PWMCONF    = 7'h70;

  // ---------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] sync_in;
  logic [4:0] sync_out;
  logic       sclk_s, cs_n_s, mosi_s, step_s, dir_s;
  logic       sclk_prev_q, cs_n_prev_q, step_prev_q;

  assign sync_in  = {dir_in, step_in, spi.mosi_in, spi.cs_n_in, spi.sclk_in};
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign sclk_s   = sync_out[0];
  assign cs_n_s   = sync_out[1];
  assign mosi_s   = sync_out[2];
  assign step_s   = sync_out[3];
  assign dir_s    = sync_out[4];

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= SYNC_IDLE;
      end
      sclk_prev_q <= 1'b1;
      cs_n_prev_q <= 1'b1;
      step_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= sync_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sclk_prev_q <= sclk_s;
      cs_n_prev_q <= cs_n_s;
      step_prev_q <= step_s;
    end
  end

  logic cs_fall, cs_rise, sclk_rise, sclk_fall, step_rise;

  assign cs_fall   =  cs_n_prev_q & ~cs_n_s;
  assign cs_rise   = ~cs_n_prev_q &  cs_n_s;
  assign sclk_rise = ~sclk_prev_q &  sclk_s & ~cs_n_s;
  assign sclk_fall =  sclk_prev_q & ~sclk_s & ~cs_n_s;
  assign step_rise = ~step_prev_q &  step_s;

  // ---------------------------------------------------------------------
  // Step interval and microstep counter
  // ---------------------------------------------------------------------
  logic [TSTEP_WIDTH-1:0] interval_q;
  logic [TSTEP_WIDTH-1:0] interval_next;
  logic [TSTEP_WIDTH-1:0] tstep_q;
  logic [9:0]             mscnt_q;
  logic                   standstill;

  assign interval_next = (interval_q == TSTEP_MAX) ? TSTEP_MAX
                                                    : interval_q + TSTEP_WIDTH'(1);
  assign standstill    = (tstep_q == TSTEP_MAX);

  // TSTEP captures the incremented count so it equals the number of clk_in
  // cycles between consecutive step edges.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      interval_q <= '0;
      tstep_q    <= TSTEP_MAX;
      mscnt_q    <= '0;
    end else if (step_rise) begin
      interval_q <= '0;
      tstep_q    <= interval_next;
      mscnt_q    <= dir_s ? mscnt_q + 10'd1 : mscnt_q - 10'd1;
    end else begin
      interval_q <= interval_next;
      if (interval_q == TSTEP_MAX) begin
        tstep_q <= TSTEP_MAX;
      end
    end
  end

  // ---------------------------------------------------------------------
  // SPI frame engine and register file
  // ---------------------------------------------------------------------
  logic [5:0]  bit_cnt_q;
  logic [39:0] rx_q;
  logic [39:0] tx_q;
  logic        miso_q;
  logic        commit_pend_q;
  logic [31:0] read_latch_q;
  logic [2:0]  gstat_q;
  logic [31:0] gconf_q, ihold_irun_q, tpowerdown_q, thigh_q, chopconf_q, pwmconf_q;
  logic [7:0]  status;
  logic [6:0]  frame_addr;
  logic [31:0] rd_data;

  assign status     = {4'b0, standstill, 2'b0, gstat_q[0]};
  assign frame_addr = rx_q[38:32];

  always_comb begin
    rd_data = '0;
    case (frame_addr)
      ADDR_GCONF:    rd_data = gconf_q;
      ADDR_GSTAT:    rd_data = {29'b0, gstat_q};
      ADDR_TSTEP:    rd_data = 32'(tstep_q);
      ADDR_MSCNT:    rd_data = {22'b0, mscnt_q};
      ADDR_CHOPCONF: rd_data = chopconf_q;
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      bit_cnt_q       <= '0;
      rx_q            <= '0;
      tx_q            <= '0;
      miso_q          <= 1'b0;
      commit_pend_q   <= 1'b0;
      read_latch_q    <= '0;
      gstat_q         <= 3'b001;
      gconf_q         <= '0;
      ihold_irun_q    <= '0;
      tpowerdown_q    <= '0;
      thigh_q         <= '0;
      chopconf_q      <= '0;
      pwmconf_q       <= '0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
      commit_pend_q   <= 1'b0;

      if (cs_fall) begin
        bit_cnt_q <= '0;
        tx_q      <= {status, read_latch_q};
        miso_q    <= status[7];
      end else if (cs_rise) begin
        if (bit_cnt_q == FRAME_BITS) begin
          commit_pend_q <= 1'b1;
        end else begin
          frame_error_out <= 1'b1;
        end
      end else if (sclk_rise) begin
        rx_q <= {rx_q[38:0], mosi_s};
        if (bit_cnt_q != 6'd63) begin
          bit_cnt_q <= bit_cnt_q + 6'd1;
        end
      end else if (sclk_fall) begin
        // Bit 39 is already on miso from CS fall, so every falling edge shifts.
        tx_q   <= {tx_q[38:0], 1'b0};
        miso_q <= tx_q[38];
      end

      // Commit one cycle after CS rise; read_latch takes the pre-write value
      // and GSTAT clears after being latched.
      if (commit_pend_q) begin
        frame_done_out <= 1'b1;
        read_latch_q   <= rd_data;
        if (frame_addr == ADDR_GSTAT) begin
          gstat_q <= '0;
        end
        if (rx_q[39]) begin
          case (frame_addr)
            ADDR_GCONF:      gconf_q      <= rx_q[31:0];
            ADDR_IHOLD_IRUN: ihold_irun_q <= rx_q[31:0];
            ADDR_TPOWERDOWN: tpowerdown_q <= rx_q[31:0];
            ADDR_THIGH:      thigh_q      <= rx_q[31:0];
            ADDR_CHOPCONF:   chopconf_q   <= rx_q[31:0];
            ADDR_PWMCONF:    pwmconf_q    <= rx_q[31:0];
            default:         ;
          endcase
        end
      end
    end
  end

  // Write-only shadows kept for a soft driver; not yet routed to outputs.
  logic unused_regs;
  assign unused_regs = ^{tpowerdown_q, thigh_q, pwmconf_q};

  assign spi.miso_out   = miso_q;
  assign gconf_out      = gconf_q;
  assign chopconf_out   = chopconf_q;
  assign ihold_irun_out = ihold_irun_q;

endmodule

// File: tb/tb_tmc_spi_responder.sv
// Directed testbench for tmc_spi_responder: drives 40-bit SPI frames and
// step pulses, compares responses and shadow outputs with hand-computed values.
module tb_tmc_spi_responder;

  logic        clk_in;
  logic        reset_n_in;
  logic        step_in;
  logic        dir_in;
  logic [31:0] gconf_out;
  logic [31:0] chopconf_out;
  logic [31:0] ihold_irun_out;
  logic        frame_done_out;
  logic        frame_error_out;

  tmc_spi_responder_if spi ();

  tmc_spi_responder #(
    .SYNC_STAGES (2),
    .TSTEP_WIDTH (20)
  ) dut (
    .clk_in          (clk_in),
    .reset_n_in      (reset_n_in),
    .spi             (spi),
    .step_in         (step_in),
    .dir_in          (dir_in),
    .gconf_out       (gconf_out),
    .chopconf_out    (chopconf_out),
    .ihold_irun_out  (ihold_irun_out),
    .frame_done_out  (frame_done_out),
    .frame_error_out (frame_error_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks;
  int errors;
  int done_cnt;
  int err_cnt;

  always @(posedge clk_in) begin
    if (frame_done_out)  done_cnt <= done_cnt + 1;
    if (frame_error_out) err_cnt  <= err_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clk_in);
  endtask

  // Initiator samples miso just before each falling SCLK edge.
  task automatic spi_xfer(input logic [39:0] tx, input int unsigned nbits,
                          output logic [39:0] rx);
    rx = '0;
    spi.cs_n_in = 1'b0;
    wait_cycles(6);
    for (int unsigned i = 0; i < nbits; i++) begin
      rx[39-i]    = spi.miso_out;
      spi.sclk_in = 1'b0;
      spi.mosi_in = tx[39-i];
      wait_cycles(4);
      spi.sclk_in = 1'b1;
      wait_cycles(4);
    end
    wait_cycles(2);
    spi.cs_n_in = 1'b1;
    wait_cycles(12);
  endtask

  task automatic step_pulses(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step_in = 1'b1;
      wait_cycles(4);
      step_in = 1'b0;
      wait_cycles(96);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [39:0] rx;
    int done_before;
    int err_before;

    checks = 0; errors = 0; done_cnt = 0; err_cnt = 0;
    reset_n_in  = 1'b0;
    spi.sclk_in = 1'b1;
    spi.cs_n_in = 1'b1;
    spi.mosi_in = 1'b0;
    step_in     = 1'b0;
    dir_in      = 1'b1;
    wait_cycles(5);
    check_eq("rst_miso", {39'b0, spi.miso_out}, 40'h0);
    reset_n_in = 1'b1;
    wait_cycles(5);
    check_eq("rst_gconf", {8'h0, gconf_out}, 40'h0);
    check_eq("rst_chopconf", {8'h0, chopconf_out}, 40'h0);
    check_eq("rst_ihold", {8'h0, ihold_irun_out}, 40'h0);

    // GSTAT reset flag: visible in status, returned by the following frame
    spi_xfer(40'h01_00000000, 40, rx);
    check_eq("gstat_flag_status", {39'b0, rx[32]}, 40'h1);
    check_eq("first_data", {8'h0, rx[31:0]}, 40'h0);
    spi_xfer(40'h00_00000000, 40, rx);
    check_eq("gstat_read", rx, 40'h08_00000001);
    check_eq("done_count", done_cnt, 2);

    // GCONF write and read-back
    spi_xfer(40'h80_00000021, 40, rx);
    check_eq("gconf_out", {8'h0, gconf_out}, 40'h00000021);
    spi_xfer(40'h00_00000000, 40, rx);
    check_eq("gconf_rd1", rx, 40'h08_00000000);
    spi_xfer(40'h00_00000000, 40, rx);
    check_eq("gconf_rd2", rx, 40'h08_00000021);

    // CHOPCONF write, read, then the following frame carries the value
    spi_xfer(40'hEC_30188113, 40, rx);
    check_eq("chopconf_out", {8'h0, chopconf_out}, 40'h30188113);
    spi_xfer(40'h6C_00000000, 40, rx);
    check_eq("chop_rd_prewrite", rx, 40'h08_00000000);
    spi_xfer(40'h90_00071F0A, 40, rx);
    check_eq("chop_rd", rx, 40'h08_30188113);
    check_eq("ihold_out", {8'h0, ihold_irun_out}, 40'h00071F0A);

    // Five steps at 100-cycle spacing, counting up
    dir_in = 1'b1;
    wait_cycles(10);
    step_pulses(5);
    spi_xfer(40'h12_00000000, 40, rx);
    check_eq("wo_read_zero", rx, 40'h00_00000000);
    spi_xfer(40'h6A_00000000, 40, rx);
    check_eq("tstep_rd", rx, 40'h00_00000064);
    spi_xfer(40'h00_00000000, 40, rx);
    check_eq("mscnt_up", rx, 40'h00_00000005);

    // Count down through zero
    dir_in = 1'b0;
    wait_cycles(10);
    step_pulses(6);
    spi_xfer(40'h6A_00000000, 40, rx);
    check_eq("mscnt_rd_prev", rx, 40'h00_00000021);
    spi_xfer(40'h6A_00000000, 40, rx);
    check_eq("mscnt_wrap", rx, 40'h00_000003FF);

    // Short (24-bit) write frame: error, no commit, latch kept
    done_before = done_cnt;
    err_before  = err_cnt;
    spi_xfer({24'h80FFFF, 16'h0}, 24, rx);
    check_eq("short_err_pulse", err_cnt, err_before + 1);
    check_eq("short_no_done", done_cnt, done_before);
    check_eq("short_gconf", {8'h0, gconf_out}, 40'h00000021);
    spi_xfer(40'h00_00000000, 40, rx);
    check_eq("short_latch_kept", rx, 40'h00_000003FF);

    // Reset asserted in the middle of a frame (bit 17)
    done_before = done_cnt;
    err_before  = err_cnt;
    spi.cs_n_in = 1'b0;
    wait_cycles(6);
    for (int unsigned i = 0; i < 17; i++) begin
      spi.sclk_in = 1'b0;
      spi.mosi_in = 1'b1;
      wait_cycles(4);
      spi.sclk_in = 1'b1;
      wait_cycles(4);
    end
    spi.sclk_in = 1'b0;
    wait_cycles(2);
    reset_n_in = 1'b0;
    wait_cycles(2);
    check_eq("midrst_miso", {39'b0, spi.miso_out}, 40'h0);
    spi.cs_n_in = 1'b1;
    spi.sclk_in = 1'b1;
    wait_cycles(4);
    reset_n_in = 1'b1;
    wait_cycles(12);
    check_eq("midrst_no_done", done_cnt, done_before);
    check_eq("midrst_no_err", err_cnt, err_before);
    check_eq("midrst_gconf", {8'h0, gconf_out}, 40'h0);
    check_eq("midrst_chopconf", {8'h0, chopconf_out}, 40'h0);
    check_eq("midrst_ihold", {8'h0, ihold_irun_out}, 40'h0);
    spi_xfer(40'h01_00000000, 40, rx);
    check_eq("midrst_latch", rx, 40'h09_00000000);
    spi_xfer(40'h00_00000000, 40, rx);
    check_eq("midrst_gstat", rx, 40'h08_00000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
